ddr3_ca_delay_ctrl: RTL and testbench

//  Upstream sequencer for the DDR3 address/command lane IOD delay lines.

---
 rtl/ddr3_ca_delay_ctrl.sv | 154 +++++++++++++++
 tb/tb_ddr3_ca_delay_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_ca_delay_ctrl.sv
// Sequencer for one DDR3 address/command IOD delay line: turns host load/move
// commands into spaced LOAD/MOVE/DIRECTION pulses and tracks the tap value.
module ddr3_ca_delay_ctrl #(
  parameter int TAP_W         = 8,
  parameter int MAX_TAP       = 255,
  parameter int LOAD_TAP      = 1,
  parameter int STEP_W        = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              FAB_CLK,
  input  logic              SYNC_RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_LOAD,
  input  logic              CMD_DIR,
  input  logic [STEP_W-1:0] CMD_STEPS,
  output logic              DONE,
  output logic              RANGE_ERR,
  output logic [TAP_W-1:0]  TAP_VAL,
  output logic              DELAY_LINE_LOAD,
  output logic              DELAY_LINE_MOVE,
  output logic              DELAY_LINE_DIRECTION,
  input  logic              DELAY_LINE_OUT_OF_RANGE
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] TAP_LOAD = TAP_W'(LOAD_TAP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic                load_reg, load_next;
  logic                dir_reg, dir_next;
  logic [STEP_W-1:0]   steps_reg, steps_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [TAP_W-1:0]    tap_reg, tap_next;
  logic                err_reg, err_next;

  logic                guard_ok;
  logic [TAP_W-1:0]    tap_step;
  logic [TAP_W-1:0]    tap_back;

  // A move is only legal if it cannot push the tap past either end.
  assign guard_ok = !((tap_reg == TAP_MAX && dir_reg) || (tap_reg == '0 && !dir_reg));
  assign tap_step = dir_reg ? tap_reg + TAP_W'(1) : tap_reg - TAP_W'(1);
  assign tap_back = dir_reg ? tap_reg - TAP_W'(1) : tap_reg + TAP_W'(1);

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_reg <= S_IDLE;
      load_reg  <= 1'b0;
      dir_reg   <= 1'b0;
      steps_reg <= '0;
      cnt_reg   <= '0;
      tap_reg   <= TAP_LOAD;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      load_reg  <= load_next;
      dir_reg   <= dir_next;
      steps_reg <= steps_next;
      cnt_reg   <= cnt_next;
      tap_reg   <= tap_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_next  = load_reg;
    dir_next   = dir_reg;
    steps_next = steps_reg;
    cnt_next   = cnt_reg;
    tap_next   = tap_reg;
    err_next   = err_reg;

    case (state_reg)
      S_IDLE: begin
        if (CMD_VALID) begin
          state_next = S_SETUP;
          load_next  = CMD_LOAD;
          steps_next = CMD_STEPS;
          err_next   = 1'b0;
          if (!CMD_LOAD) dir_next = CMD_DIR;
        end
      end
      S_SETUP: begin
        if (load_reg) begin
          state_next = S_PULSE;
        end else if (steps_reg == '0) begin
          state_next = S_DONE;
        end else if (!guard_ok) begin
          state_next = S_DONE;
          err_next   = 1'b1;
        end else begin
          state_next = S_PULSE;
          tap_next   = tap_step;
          steps_next = steps_reg - STEP_W'(1);
        end
      end
      S_PULSE: begin
        state_next = S_SETTLE;
        cnt_next   = CNT_LAST;
      end
      S_SETTLE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (load_reg) begin
          state_next = S_DONE;
          tap_next   = TAP_LOAD;
        end else if (DELAY_LINE_OUT_OF_RANGE) begin
          // The IOD refused the last move, so undo our tracked step.
          state_next = S_DONE;
          tap_next   = tap_back;
          err_next   = 1'b1;
        end else if (steps_reg == '0) begin
          state_next = S_DONE;
        end else if (!guard_ok) begin
          state_next = S_DONE;
          err_next   = 1'b1;
        end else begin
          state_next = S_PULSE;
          tap_next   = tap_step;
          steps_next = steps_reg - STEP_W'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    CMD_READY            = (state_reg == S_IDLE);
    DONE                 = (state_reg == S_DONE);
    DELAY_LINE_LOAD      = (state_reg == S_PULSE) && load_reg;
    DELAY_LINE_MOVE      = (state_reg == S_PULSE) && !load_reg;
    DELAY_LINE_DIRECTION = dir_reg;
    RANGE_ERR            = err_reg;
    TAP_VAL              = tap_reg;
  end

endmodule

// File: tb/tb_ddr3_ca_delay_ctrl.sv
// Randomized bench for ddr3_ca_delay_ctrl: a transaction-level model predicts
// pulse cycles, DONE cycle, final tap and error flag for each command.
module tb_ddr3_ca_delay_ctrl;

  localparam int S    = 4;
  localparam int MAXT = 255;
  localparam int LT   = 1;

  logic       clk = 1'b0;
  logic       srst;
  logic       valid;
  logic       ready;
  logic       cmd_load;
  logic       cmd_dir;
  logic [7:0] steps;
  logic       done;
  logic       range_err;
  logic [7:0] tap;
  logic       dl_load;
  logic       dl_move;
  logic       dl_dir;
  logic       oor;

  ddr3_ca_delay_ctrl #(
    .TAP_W(8), .MAX_TAP(MAXT), .LOAD_TAP(LT), .STEP_W(8), .SETTLE_CYCLES(S)
  ) dut (
    .FAB_CLK                 (clk),
    .SYNC_RST                (srst),
    .CMD_VALID               (valid),
    .CMD_READY               (ready),
    .CMD_LOAD                (cmd_load),
    .CMD_DIR                 (cmd_dir),
    .CMD_STEPS               (steps),
    .DONE                    (done),
    .RANGE_ERR               (range_err),
    .TAP_VAL                 (tap),
    .DELAY_LINE_LOAD         (dl_load),
    .DELAY_LINE_MOVE         (dl_move),
    .DELAY_LINE_DIRECTION    (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE (oor)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_cmd = 0;
  int m_tap = LT;
  int m_dir = 0;
  int m_err = 0;

  bit exp_move [0:2047];
  bit exp_load [0:2047];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predicts the whole command from the start tap and the OOR window [lo,hi].
  task automatic model(input bit l, input bit d, input int st, input int lo, input int hi,
                       output int done_c, output int new_tap, output int new_err);
    int c;
    int k;
    for (int i = 0; i < 2048; i++) begin
      exp_move[i] = 0;
      exp_load[i] = 0;
    end
    new_tap = m_tap;
    new_err = 0;
    if (l) begin
      exp_load[2] = 1;
      done_c      = 2 + S + 1;
      new_tap     = LT;
    end else if (st == 0) begin
      done_c = 2;
    end else begin
      c = 2;
      k = 0;
      done_c = 2;
      forever begin
        if ((new_tap == MAXT && d) || (new_tap == 0 && !d)) begin
          new_err = 1;
          done_c  = c;
          break;
        end
        exp_move[c] = 1;
        new_tap += d ? 1 : -1;
        k++;
        if (c + S >= lo && c + S <= hi) begin
          new_tap -= d ? 1 : -1;
          new_err = 1;
          done_c  = c + S + 1;
          break;
        end
        c += S + 1;
        if (k == st) begin
          done_c = c;
          break;
        end
      end
    end
  endtask

  task automatic run_cmd(input bit l, input bit d, input int st, input int lo, input int hi,
                         input bit hold, input int rst_at);
    int done_c;
    int new_tap;
    int new_err;
    @(posedge clk);
    #1;
    check_val("ready_c0", ready, 1);
    check_val("err_c0", range_err, m_err);
    check_val("tap_c0", tap, m_tap);
    check_val("dir_c0", dl_dir, m_dir);
    model(l, d, st, lo, hi, done_c, new_tap, new_err);
    valid    = 1'b1;
    cmd_load = l;
    cmd_dir  = d;
    steps    = 8'(st);
    oor      = 1'b0;
    if (!l) m_dir = d;
    for (int c = 1; c <= done_c; c++) begin
      @(posedge clk);
      #1;
      if (rst_at >= 0 && c == rst_at + 1) begin
        check_val("rst_ready", ready, 1);
        check_val("rst_done", done, 0);
        check_val("rst_err", range_err, 0);
        check_val("rst_tap", tap, LT);
        check_val("rst_load", dl_load, 0);
        check_val("rst_move", dl_move, 0);
        check_val("rst_dir", dl_dir, 0);
        srst  = 1'b0;
        valid = 1'b0;
        oor   = 1'b0;
        m_tap = LT;
        m_dir = 0;
        m_err = 0;
        $display("cmd %0d: reset applied at c%0d of move dir=%0b steps=%0d", n_cmd, rst_at, d, st);
        n_cmd++;
        return;
      end
      oor = (c >= lo && c <= hi);
      if (hold) begin
        valid    = 1'b1;
        cmd_load = 1'($urandom);
        cmd_dir  = 1'($urandom);
        steps    = 8'($urandom);
      end else begin
        valid = 1'b0;
      end
      check_val("move", dl_move, exp_move[c]);
      check_val("load", dl_load, exp_load[c]);
      check_val("done", done, (c == done_c) ? 1 : 0);
      check_val("ready_busy", ready, 0);
      check_val("dir", dl_dir, m_dir);
      if (c == 1) check_val("err_clr", range_err, 0);
      if (rst_at >= 0 && c == rst_at) srst = 1'b1;
    end
    valid = 1'b0;
    oor   = 1'b0;
    check_val("tap_end", tap, new_tap);
    check_val("err_end", range_err, new_err);
    m_tap = new_tap;
    m_err = new_err;
    $display("cmd %0d: load=%0b dir=%0b steps=%0d oor=[%0d,%0d] hold=%0b -> done@c%0d tap=%0d err=%0d",
             n_cmd, l, d, st, lo, hi, hold, done_c, new_tap, new_err);
    n_cmd++;
  endtask

  initial begin
    srst     = 1'b1;
    valid    = 1'b0;
    cmd_load = 1'b0;
    cmd_dir  = 1'b0;
    steps    = '0;
    oor      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", ready, 1);
    check_val("rst_done", done, 0);
    check_val("rst_err", range_err, 0);
    check_val("rst_tap", tap, LT);
    check_val("rst_load", dl_load, 0);
    check_val("rst_move", dl_move, 0);
    check_val("rst_dir", dl_dir, 0);
    srst = 1'b0;

    run_cmd(0, 1, 8, -1, -2, 0, -1);   // tap 1 -> 9
    run_cmd(1, 0, 0, -1, -2, 0, -1);   // load back to 1
    run_cmd(0, 1, 3, -1, -2, 0, -1);   // 1 -> 4
    run_cmd(0, 1, 3, 8, 11, 0, -1);    // refused on second move
    run_cmd(0, 0, 5, -1, -2, 0, -1);   // down to 0
    run_cmd(0, 0, 1, -1, -2, 0, -1);   // guard at zero
    run_cmd(0, 1, 0, -1, -2, 1, -1);   // zero steps, VALID held busy
    run_cmd(0, 1, 255, -1, -2, 0, -1); // 0 -> 255
    run_cmd(0, 1, 1, -1, -2, 0, -1);   // guard at max
    run_cmd(0, 0, 2, -1, -2, 1, -1);

    for (int i = 0; i < 40; i++) begin
      bit l;
      bit d;
      int st;
      int lo;
      int hi;
      bit hold;
      l  = ($urandom_range(0, 4) == 0);
      d  = 1'($urandom);
      st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 10));
      lo = -1;
      hi = -2;
      if ($urandom_range(0, 3) == 0) begin
        lo = int'($urandom_range(2, 2 + st * (S + 1) + S));
        hi = lo + int'($urandom_range(0, 3));
      end
      hold = ($urandom_range(0, 3) == 0);
      run_cmd(l, d, st, lo, hi, hold, -1);
    end

    run_cmd(1, 0, 0, -1, -2, 0, -1);
    run_cmd(0, 1, 3, -1, -2, 0, 9);    // reset mid-move
    run_cmd(0, 1, 2, -1, -2, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
